// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read-channel slave serving bursts from a 1-cycle-latency word SRAM
// Ports: clk/rst_n (async active-low); AR channel arvalid/arready/araddr/arid/arlen/arsize/arburst;
//        R channel rvalid/rready/rdata/rresp/rlast/rid; SRAM port mem_en/mem_addr/mem_rdata.
module axi_rd_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0010_0000,
    parameter int          MEM_AW     = 18,
    parameter int          LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [3:0]        rid,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, WAIT, FETCH, CAPT, RESP} state_t;
    state_t state, state_nx;
    logic [31:0] addr, off, step, wmask, addr_nx;
    logic [7:0]  len, beat_cnt;
    logic [2:0]  size;
    logic [1:0]  burst, resp_c;
    logic [3:0]  cnt;
    logic        ar_hs, r_hs, last_beat, wrap_ok, misalign;
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign last_beat = beat_cnt == len;
    // Unsigned offset: anything below BASE_ADDR wraps to a huge value and fails the window test too.
    assign off       = addr - BASE_ADDR;
    assign step      = 32'd1 << size;
    assign wmask     = ((32'(len) + 32'd1) << size) - 32'd1;
    assign wrap_ok   = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    assign misalign  = (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    assign mem_addr  = off[MEM_AW+1:2];
    always_comb begin
        resp_c = off >= SIZE_BYTES ? 2'b11 :
                 (size > 3'd2 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok) || misalign) ? 2'b10 : 2'b00;
        // WRAP keeps the bits above the block size and increments only inside the block.
        addr_nx = burst == 2'b01 ? addr + step :
                  burst == 2'b10 ? (addr & ~wmask) | ((addr + step) & wmask) : addr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ar_hs ? (LATENCY == 0 ? FETCH : WAIT) : IDLE;
            WAIT:    state_nx = cnt == 4'd1 ? FETCH : WAIT;
            FETCH:   state_nx = CAPT;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = r_hs ? (last_beat ? IDLE : FETCH) : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        arready = state == IDLE;
        rvalid  = state == RESP;
        mem_en  = state == FETCH && resp_c == 2'b00;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            rid      <= '0;
            len      <= '0;
            size     <= '0;
            burst    <= '0;
            beat_cnt <= '0;
            cnt      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
        end else begin
            if (ar_hs) begin
                addr     <= araddr;
                rid      <= arid;
                len      <= arlen;
                size     <= arsize;
                burst    <= arburst;
                beat_cnt <= '0;
                cnt      <= 4'(LATENCY);
            end
            if (state == WAIT) cnt <= cnt - 4'd1;
            // Address is unchanged between FETCH and CAPT, so resp_c here matches the strobe decision.
            if (state == CAPT) begin
                rdata <= resp_c == 2'b00 ? mem_rdata : 32'd0;
                rresp <= resp_c;
                rlast <= last_beat;
            end
            if (r_hs) begin
                rlast <= 1'b0;
                if (!last_beat) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    addr     <= addr_nx;
                end
            end
        end
    end
endmodule
